// File: rtl/benes_ctrl_sched.sv
// Skews per-stage Benes control slices so stage s sees a job's bits s cycles after entry, tracks validity/ID, gates admission by credits.
// Optional BENES_CTRL_HOLD_EN: idle stages repeat their last valid slice instead of driving 0.
module benes_ctrl_sched #(
  parameter int SIZE    = 32,
  parameter int ID_W    = 4,
  parameter int CREDITS = 4,
  localparam int TAGWIDTH = $clog2(SIZE),
  localparam int STAGES   = 2*TAGWIDTH-1,
  localparam int HALF     = SIZE/2,
  localparam int BITWIDTH = STAGES*HALF,
  localparam int CW       = $clog2(CREDITS+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_ctrl,
  input  logic [ID_W-1:0]     in_id,
  output logic [BITWIDTH-1:0] ctrl_bits,
  output logic [STAGES-1:0]   stage_valid,
  output logic                out_valid,
  output logic [ID_W-1:0]     out_id,
  input  logic                cred_return,
  output logic [CW-1:0]       credit_cnt,
  output logic                err_credit_ovf
);

  logic [CW-1:0] r_credit;
  logic          r_err;
  logic          w_ready;
  logic          w_accept;
  logic          w_ovf;
  logic          w_ret;

  // in_ready comes from registered credit state only
  assign w_ready  = (r_credit != '0);
  assign w_accept = in_valid && w_ready;
  assign w_ovf    = cred_return && (r_credit == CW'(CREDITS)) && !w_accept;
  assign w_ret    = cred_return && !w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= CW'(CREDITS);
      r_err    <= 1'b0;
    end else begin
      r_credit <= r_credit - CW'(w_accept) + CW'(w_ret);
      r_err    <= r_err | w_ovf;
    end
  end

  assign in_ready       = w_ready;
  assign credit_cnt     = r_credit;
  assign err_credit_ovf = r_err;

  // Slot k keeps only the slices for stages k..STAGES-1; each hop drops the lowest one.
  for (genvar k = 1; k < STAGES; k++) begin : g_slot
    localparam int W = (STAGES-k)*HALF;
    logic [W-1:0]    r_ctrl;
    logic            r_vld;
    logic [ID_W-1:0] r_id;
    logic [W-1:0]    w_prev_ctrl;
    logic            w_prev_vld;
    logic [ID_W-1:0] w_prev_id;

    if (k == 1) begin : g_src
      assign w_prev_ctrl = in_ctrl[BITWIDTH-1:HALF];
      assign w_prev_vld  = w_accept;
      assign w_prev_id   = in_id;
    end else begin : g_src
      assign w_prev_ctrl = g_slot[k-1].r_ctrl[W+HALF-1:HALF];
      assign w_prev_vld  = g_slot[k-1].r_vld;
      assign w_prev_id   = g_slot[k-1].r_id;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ctrl <= '0;
        r_vld  <= 1'b0;
        r_id   <= '0;
      end else begin
        r_ctrl <= w_prev_ctrl;
        r_vld  <= w_prev_vld;
        r_id   <= w_prev_id;
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [HALF-1:0] w_live;
    logic [HALF-1:0] w_idle;
    logic            w_vld;

    if (s == 0) begin : g_src
      assign w_live = in_ctrl[HALF-1:0];
      assign w_vld  = w_accept;
    end else begin : g_src
      assign w_live = g_slot[s].r_ctrl[HALF-1:0];
      assign w_vld  = g_slot[s].r_vld;
    end

`ifdef BENES_CTRL_HOLD_EN
    logic [HALF-1:0] r_hold;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hold <= '0;
      end else if (w_vld) begin
        r_hold <= w_live;
      end
    end
    assign w_idle = r_hold;
`else
    assign w_idle = '0;
`endif

    assign ctrl_bits[s*HALF +: HALF] = w_vld ? w_live : w_idle;
    assign stage_valid[s]            = w_vld;
  end

  assign out_valid = g_slot[STAGES-1].r_vld;
  assign out_id    = g_slot[STAGES-1].r_vld ? g_slot[STAGES-1].r_id : '0;

endmodule
